tweezer_lock_sequencer: RTL and testbench
=========================================

Name: tweezer_lock_sequencer

Overview:
- Sequences engagement of the tweezer PI loop: loads kp/ki, pulses the PI reset, waits a settle time, then ramps the setpoint from the current bead ray to the target.
- After ramping, monitors the lock error and drops to a safe state on a persistent excursion.
- Sits between the host register bank and the tweezer controller's PI configuration ports, and consumes that controller's ray/valid outputs.

Parameters:
- DATA_WIDTH, 16, width of ray, setpoint, step and window (signed Q1.15 for ray and setpoint).
- COEFF_WIDTH, 10, width of kp/ki coefficients.
- CNT_WIDTH, 16, width of the settle and ramp-interval counters.
- FAULT_CNT_WIDTH, 8, width of the consecutive-fault counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse; engage from IDLE, or retarget from RAMP/LOCKED
- stop  in  1  pulse; disengage from any state; has priority over start
- target_setpoint  in  DATA_WIDTH  signed final setpoint, sampled on an accepted start
- ramp_step  in  DATA_WIDTH  unsigned setpoint increment per step; 0 means jump to target
- ramp_interval  in  CNT_WIDTH  cycles between steps, minus 1
- settle_cycles  in  CNT_WIDTH  cycles of PI-enabled hold before ramping
- kp_in, ki_in  in  COEFF_WIDTH  coefficients to load
- ray  in  DATA_WIDTH  signed bead distance from the tweezer controller
- ray_valid  in  1  ray qualifier
- fault_window  in  DATA_WIDTH  unsigned maximum allowed |ray-setpoint|
- fault_limit  in  FAULT_CNT_WIDTH  consecutive out-of-window samples that trip a fault; 0 disables fault detection
- PI_reset, PI_enable, PI_freeze  out  1  PI control signals
- PI_setpoint  out  DATA_WIDTH  registered signed setpoint
- PI_kp, PI_ki  out  COEFF_WIDTH  registered coefficients
- PI_kp_update, PI_ki_update  out  1  single-cycle load strobes
- state  out  3  current state encoding
- locked  out  1  high in LOCKED
- fault  out  1  sticky fault flag

Behaviour:
- Reset (async): state=IDLE and all outputs 0, except PI_reset=1. The last_ray register clears to 0.
- last_ray: updated with ray on every ray_valid, in every state.
- Registered outputs are decoded from the next state, so each state's outputs appear in the cycle the FSM enters it.
- IDLE (0): PI_enable=0, PI_reset=1. On start without stop: go to LOAD.
- LOAD (1), 1 cycle:
  - PI_kp<=kp_in, PI_ki<=ki_in; PI_kp_update=PI_ki_update=1 for exactly this cycle.
  - Latch target, step and interval.
  - PI_setpoint<=last_ray (bumpless start).
  - Next state: PRERESET.
- PRERESET (2), exactly 2 cycles: PI_reset=1, PI_enable=0. Next state: SETTLE.
- SETTLE (3):
  - PI_reset=0, PI_enable=1.
  - Counter loads settle_cycles on entry and decrements each cycle.
  - Leave for RAMP in the cycle the counter reads 0; settle_cycles=0 gives 1 cycle in SETTLE.
- RAMP (4):
  - Interval counter loads the latched interval.
  - On reaching 0: PI_setpoint moves toward target by min(step, |target-PI_setpoint|), then the counter reloads.
  - Difference is computed in DATA_WIDTH+1 bits; no overflow is possible.
  - Step=0: PI_setpoint<=target on the first expiry.
  - Exit to LOCKED in the cycle after PI_setpoint==target.
- LOCKED (5):
  - locked=1.
  - On each ray_valid: err=|ray-PI_setpoint| in DATA_WIDTH+1 bits.
  - err>fault_window: fault counter increments, saturating. Otherwise the counter clears.
  - Counter reaching fault_limit (nonzero): go to FAULT.
- Retarget: start in RAMP or LOCKED latches the new target, step and interval and enters RAMP with no PI reset and no coefficient reload. The fault counter clears.
- FAULT (6):
  - PI_enable=0, PI_reset=1, PI_freeze=1, fault=1.
  - start is ignored.
  - Only stop exits, to IDLE; stop clears fault.
- stop in any state: IDLE next cycle, and fault clears.
- start and stop in the same cycle: stop wins.
- PI_freeze is 0 in all states except FAULT.
- Unused encoding 7: go to IDLE.

Decomposition:
- Package tweezer_seq_pkg:
  - state encodings IDLE..FAULT (3-bit localparams);
  - PRERESET_CYCLES=2.
- Sub-module tweezer_setpoint_ramp:
  - owns the interval counter and the saturating step toward target;
  - inputs: load, start value, target, step, interval, run;
  - outputs: setpoint, at_target.
- The FSM and fault monitor stay in the top module.

Test Plan:
- Reset, then start with kp=0x040, ki=0x010, settle_cycles=3, last ray=0x1000, target=0x1400, step=0x0100, interval=1:
  - LOAD strobes both updates for 1 cycle;
  - PI_reset high 2 cycles, then SETTLE for 4 cycles;
  - setpoint goes 0x1100, 0x1200, 0x1300, 0x1400, one step every 2 cycles;
  - locked rises 1 cycle after setpoint reaches 0x1400.
- Non-multiple step: last ray=0x0000, target=-0x0150, step=0x0100: setpoint goes -0x0100 then -0x0150, then LOCKED.
- Fault trip: LOCKED at 0x1400, fault_window=0x0080, fault_limit=3:
  - rays 0x1500, 0x1500, 0x1400, 0x1500 give no fault (counter clears);
  - three consecutive 0x1500 give FAULT, with PI_enable=0, PI_freeze=1, fault=1;
  - start is then ignored; stop returns to IDLE with fault=0.
- Retarget: in LOCKED, start with target=0x1000, step=0: RAMP, setpoint=0x1000 after one interval, no kp/ki update strobe, no PI_reset pulse.
- Priority: start and stop asserted together in IDLE stays IDLE. stop during SETTLE gives IDLE next cycle with PI_enable=0.
- Async reset asserted mid-RAMP (no clock edge): all outputs go to reset values immediately and state reads 0. With step=0 and fault_limit=0, LOCKED never trips regardless of error.

Source files
------------

// File: rtl/tweezer_seq_pkg.sv
// Shared state encoding and timing constants for the tweezer lock sequencer.
package tweezer_seq_pkg;

    localparam int unsigned STATE_WIDTH     = 3;
    localparam int unsigned PRERESET_CYCLES = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PRERESET = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_RAMP     = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_FAULT    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/tweezer_setpoint_ramp.sv
// Setpoint ramp: steps the setpoint toward the target once per interval,
// never overshooting; a zero step jumps straight to the target.
module tweezer_setpoint_ramp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] start_value,
    input  logic signed [DATA_WIDTH-1:0] target,
    input  logic        [DATA_WIDTH-1:0] step,
    input  logic        [CNT_WIDTH-1:0]  interval,
    input  logic                         run,
    input  logic                         rearm,
    output logic signed [DATA_WIDTH-1:0] setpoint,
    output logic                         at_target_c
);

    localparam int unsigned EXT_WIDTH = DATA_WIDTH + 1;

    logic        [CNT_WIDTH-1:0]  cnt_q;
    logic        [CNT_WIDTH-1:0]  cnt_d;
    logic signed [DATA_WIDTH-1:0] setpoint_d;
    logic signed [DATA_WIDTH-1:0] step_value_c;
    logic signed [EXT_WIDTH-1:0]  diff_c;
    logic        [EXT_WIDTH-1:0]  dist_c;
    logic                         fits_c;
    logic                         fire_c;

    // Next interval count and next setpoint (saturating step toward target)
    always_comb begin
        diff_c      = EXT_WIDTH'(target) - EXT_WIDTH'(setpoint);
        dist_c      = diff_c[DATA_WIDTH] ? $unsigned(-diff_c) : $unsigned(diff_c);
        fits_c      = (step == '0) || (EXT_WIDTH'(step) >= dist_c);
        at_target_c = (setpoint == target);
        fire_c      = run && !rearm && (cnt_q == interval);

        if (fits_c) begin
            step_value_c = target;
        end else if (diff_c[DATA_WIDTH]) begin
            step_value_c = DATA_WIDTH'($unsigned(setpoint) - step);
        end else begin
            step_value_c = DATA_WIDTH'($unsigned(setpoint) + step);
        end

        if (load || rearm || !run || fire_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        setpoint_d = setpoint;
        if (load) begin
            setpoint_d = start_value;
        end else if (fire_c) begin
            setpoint_d = step_value_c;
        end
    end

    // Interval counter and setpoint registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            setpoint <= '0;
        end else begin
            cnt_q    <= cnt_d;
            setpoint <= setpoint_d;
        end
    end

endmodule

// File: rtl/tweezer_lock_sequencer.sv
// Tweezer PI engagement sequencer: coefficient load, PI reset pulse, settle,
// setpoint ramp, then lock monitoring with a persistent-excursion fault trip.
module tweezer_lock_sequencer
    import tweezer_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned COEFF_WIDTH     = 10,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned FAULT_CNT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop,
    input  logic signed [DATA_WIDTH-1:0]      target_setpoint,
    input  logic        [DATA_WIDTH-1:0]      ramp_step,
    input  logic        [CNT_WIDTH-1:0]       ramp_interval,
    input  logic        [CNT_WIDTH-1:0]       settle_cycles,
    input  logic        [COEFF_WIDTH-1:0]     kp_in,
    input  logic        [COEFF_WIDTH-1:0]     ki_in,
    input  logic signed [DATA_WIDTH-1:0]      ray,
    input  logic                              ray_valid,
    input  logic        [DATA_WIDTH-1:0]      fault_window,
    input  logic        [FAULT_CNT_WIDTH-1:0] fault_limit,
    output logic                              PI_reset,
    output logic                              PI_enable,
    output logic                              PI_freeze,
    output logic signed [DATA_WIDTH-1:0]      PI_setpoint,
    output logic        [COEFF_WIDTH-1:0]     PI_kp,
    output logic        [COEFF_WIDTH-1:0]     PI_ki,
    output logic                              PI_kp_update,
    output logic                              PI_ki_update,
    output logic        [STATE_WIDTH-1:0]     state,
    output logic                              locked,
    output logic                              fault
);

    localparam int unsigned EXT_WIDTH = DATA_WIDTH + 1;

    seq_state_t                  state_q;
    seq_state_t                  state_d;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0]        cnt_d;
    logic [FAULT_CNT_WIDTH-1:0]  fcnt_q;
    logic [FAULT_CNT_WIDTH-1:0]  fcnt_d;
    logic signed [DATA_WIDTH-1:0] last_ray_q;
    logic signed [DATA_WIDTH-1:0] target_q;
    logic [DATA_WIDTH-1:0]       step_q;
    logic [CNT_WIDTH-1:0]        interval_q;

    logic                        accept_c;
    logic                        retarget_c;
    logic                        trip_c;
    logic                        ramp_load_c;
    logic                        ramp_run_c;
    logic                        at_target_c;
    logic signed [EXT_WIDTH-1:0] err_diff_c;
    logic [EXT_WIDTH-1:0]        err_mag_c;

    logic                        pi_reset_d;
    logic                        pi_enable_d;
    logic                        pi_freeze_d;
    logic                        locked_d;
    logic                        fault_d;
    logic                        coeff_load_d;

    assign state = state_q;

    // Next state, counters and next-state-decoded outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        accept_c   = 1'b0;
        retarget_c = 1'b0;

        err_diff_c = EXT_WIDTH'(ray) - EXT_WIDTH'(PI_setpoint);
        err_mag_c  = err_diff_c[DATA_WIDTH] ? $unsigned(-err_diff_c) : $unsigned(err_diff_c);

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end

        // Consecutive out-of-window samples, only counted while locked
        if (state_q != ST_LOCKED) begin
            fcnt_d = '0;
        end else if (ray_valid) begin
            if (err_mag_c > EXT_WIDTH'(fault_window)) begin
                fcnt_d = (fcnt_q == '1) ? fcnt_q : fcnt_q + FAULT_CNT_WIDTH'(1);
            end else begin
                fcnt_d = '0;
            end
        end
        trip_c = (state_q == ST_LOCKED) && (fault_limit != '0) && (fcnt_d >= fault_limit);

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_LOAD;
                        accept_c = 1'b1;
                    end
                end
                ST_LOAD:     state_d = ST_PRERESET;
                ST_PRERESET: if (cnt_q == '0) state_d = ST_SETTLE;
                ST_SETTLE:   if (cnt_q == '0) state_d = ST_RAMP;
                ST_RAMP: begin
                    if (start) begin
                        accept_c   = 1'b1;
                        retarget_c = 1'b1;
                    end else if (at_target_c) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (start) begin
                        state_d    = ST_RAMP;
                        accept_c   = 1'b1;
                        retarget_c = 1'b1;
                    end else if (trip_c) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT:    state_d = ST_FAULT;
                default:     state_d = ST_IDLE;
            endcase
        end

        // Timed states load their counter on entry
        if ((state_d == ST_PRERESET) && (state_q != ST_PRERESET)) begin
            cnt_d = CNT_WIDTH'(PRERESET_CYCLES - 1);
        end else if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
            cnt_d = settle_cycles;
        end

        if (retarget_c) begin
            fcnt_d = '0;
        end

        ramp_load_c = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        ramp_run_c  = (state_q == ST_RAMP) && !stop;

        pi_reset_d   = (state_d == ST_IDLE) || (state_d == ST_PRERESET) || (state_d == ST_FAULT);
        pi_enable_d  = (state_d == ST_SETTLE) || (state_d == ST_RAMP) || (state_d == ST_LOCKED);
        pi_freeze_d  = (state_d == ST_FAULT);
        fault_d      = (state_d == ST_FAULT);
        locked_d     = (state_d == ST_LOCKED);
        coeff_load_d = (state_d == ST_LOAD);
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            last_ray_q   <= '0;
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= '0;
            PI_reset     <= 1'b1;
            PI_enable    <= 1'b0;
            PI_freeze    <= 1'b0;
            PI_kp        <= '0;
            PI_ki        <= '0;
            PI_kp_update <= 1'b0;
            PI_ki_update <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            if (ray_valid) begin
                last_ray_q <= ray;
            end
            if (accept_c) begin
                target_q   <= target_setpoint;
                step_q     <= ramp_step;
                interval_q <= ramp_interval;
            end
            if (coeff_load_d) begin
                PI_kp <= kp_in;
                PI_ki <= ki_in;
            end
            PI_reset     <= pi_reset_d;
            PI_enable    <= pi_enable_d;
            PI_freeze    <= pi_freeze_d;
            PI_kp_update <= coeff_load_d;
            PI_ki_update <= coeff_load_d;
            locked       <= locked_d;
            fault        <= fault_d;
        end
    end

    // Setpoint ramp generator
    tweezer_setpoint_ramp #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ramp (
        .clk         (clk),
        .reset       (reset),
        .load        (ramp_load_c),
        .start_value (last_ray_q),
        .target      (target_q),
        .step        (step_q),
        .interval    (interval_q),
        .run         (ramp_run_c),
        .rearm       (retarget_c),
        .setpoint    (PI_setpoint),
        .at_target_c (at_target_c)
    );

endmodule

// File: tb/tb_tweezer_lock_sequencer.sv
// Directed bench for the tweezer lock sequencer with a setpoint scoreboard.
module tb_tweezer_lock_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic signed [15:0] target_setpoint;
    logic [15:0]        ramp_step;
    logic [15:0]        ramp_interval;
    logic [15:0]        settle_cycles;
    logic [9:0]         kp_in;
    logic [9:0]         ki_in;
    logic signed [15:0] ray;
    logic               ray_valid;
    logic [15:0]        fault_window;
    logic [7:0]         fault_limit;
    logic               PI_reset;
    logic               PI_enable;
    logic               PI_freeze;
    logic signed [15:0] PI_setpoint;
    logic [9:0]         PI_kp;
    logic [9:0]         PI_ki;
    logic               PI_kp_update;
    logic               PI_ki_update;
    logic [2:0]         state;
    logic               locked;
    logic               fault;

    int                 n_assert = 0;
    int                 n_fail   = 0;
    logic [15:0]        exp_q[$];
    logic [15:0]        prev_sp = 16'h0000;

    always #5 clk = ~clk;

    tweezer_lock_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .target_setpoint (target_setpoint),
        .ramp_step       (ramp_step),
        .ramp_interval   (ramp_interval),
        .settle_cycles   (settle_cycles),
        .kp_in           (kp_in),
        .ki_in           (ki_in),
        .ray             (ray),
        .ray_valid       (ray_valid),
        .fault_window    (fault_window),
        .fault_limit     (fault_limit),
        .PI_reset        (PI_reset),
        .PI_enable       (PI_enable),
        .PI_freeze       (PI_freeze),
        .PI_setpoint     (PI_setpoint),
        .PI_kp           (PI_kp),
        .PI_ki           (PI_ki),
        .PI_kp_update    (PI_kp_update),
        .PI_ki_update    (PI_ki_update),
        .state           (state),
        .locked          (locked),
        .fault           (fault)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; setpoint moves seen in RAMP are matched against the scoreboard
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset && state == 3'd4 && 16'(PI_setpoint) !== prev_sp) begin
            if (exp_q.size() == 0) chk("sb_unexpected_step", 16'(exp_q.size()), 16'd1);
            else chk("sb_setpoint", 16'(PI_setpoint), exp_q.pop_front());
        end
        prev_sp = 16'(PI_setpoint);
    endtask

    task automatic send_ray(input logic [15:0] v);
        ray       = v;
        ray_valid = 1'b1;
        tick();
        ray_valid = 1'b0;
    endtask

    logic [15:0] fseq [8] = '{16'h1500, 16'h1500, 16'h1480, 16'h1500,
                              16'h1400, 16'h1500, 16'h1500, 16'h1500};
    logic [2:0]  fst  [8] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6};

    initial begin
        int settle_n;
        logic seen_pulse;

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        target_setpoint = '0; ramp_step = '0; ramp_interval = '0; settle_cycles = '0;
        kp_in = '0; ki_in = '0; ray = '0; ray_valid = 1'b0;
        fault_window = 16'h0080; fault_limit = 8'd3;
        tick(); tick();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pi_reset", 16'(PI_reset), 16'd1);
        chk("rst_pi_enable", 16'(PI_enable), 16'd0);
        chk("rst_setpoint", 16'(PI_setpoint), 16'h0000);
        chk("rst_kp", 16'(PI_kp), 16'h0000);
        reset = 1'b0;
        tick();

        // Full engagement with an evenly dividing ramp
        send_ray(16'h1000);
        kp_in = 10'h040; ki_in = 10'h010; settle_cycles = 16'd3;
        target_setpoint = 16'h1400; ramp_step = 16'h0100; ramp_interval = 16'd1;
        exp_q.push_back(16'h1100); exp_q.push_back(16'h1200);
        exp_q.push_back(16'h1300); exp_q.push_back(16'h1400);
        start = 1'b1; tick(); start = 1'b0;
        chk("load_state", 16'(state), 16'd1);
        chk("load_kp_upd", 16'(PI_kp_update), 16'd1);
        chk("load_ki_upd", 16'(PI_ki_update), 16'd1);
        chk("load_kp", 16'(PI_kp), 16'h0040);
        chk("load_ki", 16'(PI_ki), 16'h0010);
        chk("load_setpoint", 16'(PI_setpoint), 16'h1000);
        chk("load_pi_reset", 16'(PI_reset), 16'd0);
        tick();
        chk("pre1_state", 16'(state), 16'd2);
        chk("pre1_pi_reset", 16'(PI_reset), 16'd1);
        chk("pre1_kp_upd", 16'(PI_kp_update), 16'd0);
        tick();
        chk("pre2_state", 16'(state), 16'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("settle_state", 16'(state), 16'd3);
            chk("settle_enable", 16'(PI_enable), 16'd1);
        end
        tick();
        chk("ramp_entry", 16'(state), 16'd4);
        for (int i = 0; i < 8; i++) tick();
        chk("ramp_final_sp", 16'(PI_setpoint), 16'h1400);
        chk("ramp_not_locked", 16'(locked), 16'd0);
        tick();
        chk("lock_state", 16'(state), 16'd5);
        chk("lock_flag", 16'(locked), 16'd1);

        // Fault monitor: window boundary, clearing, then three consecutive misses
        for (int i = 0; i < 8; i++) begin
            send_ray(fseq[i]);
            chk("fault_seq_state", 16'(state), 16'(fst[i]));
        end
        chk("fault_enable", 16'(PI_enable), 16'd0);
        chk("fault_freeze", 16'(PI_freeze), 16'd1);
        chk("fault_flag", 16'(fault), 16'd1);
        chk("fault_pi_reset", 16'(PI_reset), 16'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("fault_start_ign", 16'(state), 16'd6);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("fault_stop_state", 16'(state), 16'd0);
        chk("fault_stop_flag", 16'(fault), 16'd0);
        chk("fault_stop_freeze", 16'(PI_freeze), 16'd0);

        // Non-multiple negative ramp with zero settle time
        send_ray(16'h0000);
        settle_cycles = 16'd0; target_setpoint = 16'hFEB0;
        exp_q.push_back(16'hFF00); exp_q.push_back(16'hFEB0);
        start = 1'b1; tick(); start = 1'b0;
        settle_n = 0;
        for (int i = 0; i < 60 && !locked; i++) begin
            tick();
            if (state == 3'd3) settle_n++;
        end
        chk("neg_settle_cycles", 16'(settle_n), 16'd1);
        chk("neg_locked", 16'(locked), 16'd1);
        chk("neg_setpoint", 16'(PI_setpoint), 16'hFEB0);

        // Retarget from LOCKED with a zero step: no reset pulse, no reload
        kp_in = 10'h3FF; target_setpoint = 16'h1000; ramp_step = 16'h0000;
        exp_q.push_back(16'h1000);
        start = 1'b1; tick(); start = 1'b0;
        chk("rt_state", 16'(state), 16'd4);
        chk("rt_enable", 16'(PI_enable), 16'd1);
        seen_pulse = PI_reset | PI_kp_update | PI_ki_update;
        tick();
        chk("rt_sp_hold", 16'(PI_setpoint), 16'hFEB0);
        for (int i = 0; i < 20 && !locked; i++) begin
            tick();
            seen_pulse = seen_pulse | PI_reset | PI_kp_update | PI_ki_update;
        end
        chk("rt_no_pulse", 16'(seen_pulse), 16'd0);
        chk("rt_setpoint", 16'(PI_setpoint), 16'h1000);
        chk("rt_kp_kept", 16'(PI_kp), 16'h0040);
        chk("rt_locked", 16'(locked), 16'd1);

        // fault_limit of zero never trips, whatever the error
        fault_limit = 8'd0;
        for (int i = 0; i < 6; i++) send_ray(16'h7000);
        chk("nolimit_state", 16'(state), 16'd5);
        chk("nolimit_fault", 16'(fault), 16'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_locked", 16'(state), 16'd0);

        // stop beats start; stop during SETTLE
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("prio_state", 16'(state), 16'd0);
        chk("prio_no_upd", 16'(PI_kp_update), 16'd0);
        settle_cycles = 16'd10;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10 && state != 3'd3; i++) tick();
        chk("settle_reached", 16'(state), 16'd3);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("settle_stop_state", 16'(state), 16'd0);
        chk("settle_stop_enable", 16'(PI_enable), 16'd0);

        // Asynchronous reset in the middle of RAMP
        settle_cycles = 16'd0; ramp_step = 16'h0010; ramp_interval = 16'd20;
        target_setpoint = 16'h2000;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && state != 3'd4; i++) tick();
        chk("ar_in_ramp", 16'(state), 16'd4);
        #2 reset = 1'b1;
        #1;
        chk("ar_state", 16'(state), 16'd0);
        chk("ar_pi_reset", 16'(PI_reset), 16'd1);
        chk("ar_enable", 16'(PI_enable), 16'd0);
        chk("ar_setpoint", 16'(PI_setpoint), 16'h0000);
        chk("ar_kp", 16'(PI_kp), 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after_state", 16'(state), 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
